fft_stream_harness: RTL and testbench

Synthesizable, parametrised frame player/capturer for exercising streaming FFT/IFFT cores in simulation and on the FPGA bring-up board. The player streams N-sample frames from a loadable source memory into the core's `In_Stream`/`Data_Start` inputs. The capturer records the core's `Out_Stream` frame, starting at the first `Data_Out`, into a readable capture memory. The block adds multi-frame runs, inter-frame gaps, abort, frame counters and a capture-continuity error flag.

---
 rtl/fft_stream_harness.sv | 165 ++++++++++++++++
 tb/tb_fft_stream_harness.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stream_harness.sv
// fft_stream_harness: plays N-sample frames from a loadable memory into a streaming core and captures its output frames.
module fft_stream_harness #(
   parameter int DW    = 32,
   parameter int LOG2N = 6,
   parameter int GAP_W = 8,
   parameter int FRM_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld_we,
   input  logic [LOG2N-1:0] ld_addr,
   input  logic [DW-1:0]    ld_data,
   input  logic             start,
   input  logic [FRM_W-1:0] num_frames,
   input  logic [GAP_W-1:0] gap,
   input  logic             abort,
   output logic [DW-1:0]    src_data,
   output logic             src_valid,
   input  logic [DW-1:0]    snk_data,
   input  logic             snk_valid,
   input  logic [LOG2N-1:0] rd_addr,
   output logic [DW-1:0]    rd_data,
   output logic             busy,
   output logic             done,
   output logic [FRM_W-1:0] frames_sent,
   output logic [FRM_W-1:0] frames_captured,
   output logic             capture_err
);
   typedef enum logic [1:0] {P_IDLE, P_PLAY, P_GAP} p_t;
   typedef enum logic {C_WAIT, C_CAP} c_t;
   localparam logic [LOG2N-1:0] LAST = '1;
   logic [DW-1:0] src_mem [2**LOG2N];
   logic [DW-1:0] cap_mem [2**LOG2N];
   p_t p_q, p_d;
   c_t c_q, c_d;
   logic [LOG2N-1:0] idx_q, idx_d, cidx_q, cidx_d, cap_addr;
   logic [GAP_W-1:0] gcnt_q, gcnt_d, gap_q, gap_d;
   logic [FRM_W-1:0] num_q, num_d, sent_q, sent_d, capd_q, capd_d;
   logic err_q, err_d, busy_q, busy_d, cap_we;
   logic [DW-1:0] src_data_q, src_data_d, rd_data_q;

   function automatic logic [FRM_W-1:0] sat(input logic [FRM_W-1:0] x);
      return &x ? x : x + 1'b1;
   endfunction

   always_comb begin
      p_d = p_q;
      c_d = c_q;
      idx_d = idx_q;
      cidx_d = cidx_q;
      gcnt_d = gcnt_q;
      gap_d = gap_q;
      num_d = num_q;
      sent_d = sent_q;
      capd_d = capd_q;
      err_d = err_q;
      busy_d = busy_q;
      cap_we = 1'b0;
      cap_addr = cidx_q;
      done = busy_q && p_q == P_IDLE && num_q != '0 && capd_q == num_q;
      if (abort) begin
         c_d = C_WAIT;
      end else if (c_q == C_WAIT) begin
         if (snk_valid) begin
            cap_we = 1'b1;
            cap_addr = '0;
            c_d = C_CAP;
            cidx_d = LOG2N'(1);
         end
      end else begin
         // Store every cycle of an open frame so the slot layout stays aligned to sample index.
         cap_we = 1'b1;
         err_d = err_q | ~snk_valid;
         if (cidx_q == LAST) begin
            capd_d = sat(capd_q);
            c_d = C_WAIT;
         end else
            cidx_d = cidx_q + 1'b1;
      end
      if (abort) begin
         p_d = P_IDLE;
         busy_d = 1'b0;
      end else begin
         case (p_q)
            P_IDLE:
               if (start && !busy_q) begin
                  num_d = num_frames;
                  gap_d = gap;
                  sent_d = '0;
                  capd_d = '0;
                  err_d = 1'b0;
                  busy_d = 1'b1;
                  p_d = P_PLAY;
                  idx_d = '0;
               end
            P_PLAY:
               if (idx_q == LAST) begin
                  sent_d = sat(sent_q);
                  idx_d = '0;
                  if (num_q != '0 && sat(sent_q) == num_q)
                     p_d = P_IDLE;
                  else if (gap_q != '0) begin
                     p_d = P_GAP;
                     gcnt_d = gap_q;
                  end
               end else
                  idx_d = idx_q + 1'b1;
            P_GAP:
               if (gcnt_q == GAP_W'(1))
                  p_d = P_PLAY;
               else
                  gcnt_d = gcnt_q - 1'b1;
            default: p_d = P_IDLE;
         endcase
         if (done) busy_d = 1'b0;
      end
      src_data_d = p_d == P_PLAY ? src_mem[idx_d] : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p_q <= P_IDLE;
         c_q <= C_WAIT;
         idx_q <= '0;
         cidx_q <= '0;
         gcnt_q <= '0;
         gap_q <= '0;
         num_q <= '0;
         sent_q <= '0;
         capd_q <= '0;
         err_q <= 1'b0;
         busy_q <= 1'b0;
         src_data_q <= '0;
         rd_data_q <= '0;
      end else begin
         p_q <= p_d;
         c_q <= c_d;
         idx_q <= idx_d;
         cidx_q <= cidx_d;
         gcnt_q <= gcnt_d;
         gap_q <= gap_d;
         num_q <= num_d;
         sent_q <= sent_d;
         capd_q <= capd_d;
         err_q <= err_d;
         busy_q <= busy_d;
         src_data_q <= src_data_d;
         rd_data_q <= cap_mem[rd_addr];
      end
   end

   always_ff @(posedge clk)
      if (ld_we) src_mem[ld_addr] <= ld_data;

   always_ff @(posedge clk)
      if (cap_we) cap_mem[cap_addr] <= snk_data;

   assign src_data = src_data_q;
   assign src_valid = p_q == P_PLAY;
   assign rd_data = rd_data_q;
   assign busy = busy_q;
   assign frames_sent = sent_q;
   assign frames_captured = capd_q;
   assign capture_err = err_q;
endmodule

// File: tb/tb_fft_stream_harness.sv
// tb_fft_stream_harness: directed frame runs with a 10-stage loopback core model and a sample scoreboard.
module tb_fft_stream_harness;
   localparam int DW = 32, LOG2N = 6, N = 64, GAP_W = 8, FRM_W = 8;
   logic clk = 0, rst = 1, ld_we = 0, start = 0, abort = 0, snk_valid = 0;
   logic [LOG2N-1:0] ld_addr = '0, rd_addr = '0;
   logic [DW-1:0] ld_data = '0, snk_data = '0, src_data, rd_data;
   logic [FRM_W-1:0] num_frames = '0, frames_sent, frames_captured;
   logic [GAP_W-1:0] gap = '0;
   logic src_valid, busy, done, capture_err;
   int n_tests = 0, n_fail = 0, done_cnt = 0, burst = 0, low = 0;
   int exp_q[$], bursts[$], gaps[$];
   bit prev_v = 0, flush = 0, drop = 0;
   logic [DW-1:0] d_d [10];
   bit d_v [10];

   fft_stream_harness #(.DW(DW), .LOG2N(LOG2N), .GAP_W(GAP_W), .FRM_W(FRM_W)) dut (
      .clk(clk), .rst(rst), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
      .start(start), .num_frames(num_frames), .gap(gap), .abort(abort),
      .src_data(src_data), .src_valid(src_valid), .snk_data(snk_data), .snk_valid(snk_valid),
      .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
      .frames_sent(frames_sent), .frames_captured(frames_captured), .capture_err(capture_err));

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Monitor: scoreboard pop on every valid sample, idle data must be zero, burst/gap lengths logged.
   always @(negedge clk) begin
      if (src_valid) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL src_extra: got sample %0d with none expected", src_data);
         end else
            check("src_data", src_data, 64'(exp_q.pop_front()));
         if (!prev_v) gaps.push_back(low);
         burst++;
      end else begin
         check("src_idle_zero", src_data, 0);
         if (prev_v) begin
            bursts.push_back(burst);
            burst = 0;
            low = 0;
         end
         low++;
      end
      prev_v = src_valid;
      if (done) done_cnt++;
   end

   // Core model: delay line from src to snk, optional one-cycle valid drop on sample 20.
   always @(posedge clk) begin
      #2;
      for (int i = 9; i > 0; i--) begin
         d_v[i] = d_v[i-1];
         d_d[i] = d_d[i-1];
      end
      d_v[0] = src_valid;
      d_d[0] = src_data;
      if (flush) begin
         for (int i = 0; i < 10; i++) d_v[i] = 0;
         flush = 0;
      end
      snk_data = d_d[9];
      snk_valid = d_v[9] && !(drop && d_d[9] == 20);
      if (drop && d_v[9] && d_d[9] == 20) drop = 0;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input int nf, input int g, input int nexp);
      for (int i = 0; i < nexp; i++) exp_q.push_back(i % N);
      num_frames = FRM_W'(nf);
      gap = GAP_W'(g);
      start = 1;
      tick();
      start = 0;
   endtask

   task automatic wait_idle(input int budget);
      int c = 0;
      while (busy && c < budget) begin
         tick();
         c++;
      end
      check("run_timeout_busy", busy, 0);
   endtask

   task automatic wait_sample(input int fs, input int smp);
      int c = 0;
      while (!(frames_sent == FRM_W'(fs) && src_valid && src_data == DW'(smp)) && c < 500) begin
         tick();
         c++;
      end
      check("wait_sample", 64'(frames_sent == FRM_W'(fs) && src_valid && src_data == DW'(smp)), 1);
   endtask

   task automatic readback;
      for (int k = 0; k < N; k++) begin
         rd_addr = LOG2N'(k);
         tick();
         check("rd_data", rd_data, k);
      end
   endtask

   task automatic check_reset_vals;
      check("rst_src_valid", src_valid, 0);
      check("rst_src_data", src_data, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_frames_sent", frames_sent, 0);
      check("rst_frames_captured", frames_captured, 0);
      check("rst_capture_err", capture_err, 0);
   endtask

   initial begin
      int b0, g0, d0;
      repeat (3) tick();
      check_reset_vals();
      rst = 0;
      for (int k = 0; k < N; k++) begin
         ld_we = 1;
         ld_addr = LOG2N'(k);
         ld_data = DW'(k);
         tick();
      end
      ld_we = 0;
      tick();

      // single frame
      b0 = bursts.size();
      d0 = done_cnt;
      check("pre_start_valid", src_valid, 0);
      launch(1, 0, N);
      check("first_valid", src_valid, 1);
      check("first_busy", busy, 1);
      wait_idle(400);
      check("t1_bursts", bursts.size() - b0, 1);
      check("t1_burst_len", bursts[b0], 64);
      check("t1_sent", frames_sent, 1);
      check("t1_captured", frames_captured, 1);
      check("t1_done_pulses", done_cnt - d0, 1);
      check("t1_err", capture_err, 0);
      check("t1_scoreboard_empty", exp_q.size(), 0);
      readback();

      // gapped run
      b0 = bursts.size();
      g0 = gaps.size();
      d0 = done_cnt;
      launch(3, 5, 3 * N);
      wait_idle(1000);
      check("t2_bursts", bursts.size() - b0, 3);
      for (int i = 0; i < 3; i++) check("t2_burst_len", bursts[b0+i], 64);
      check("t2_gaps", gaps.size() - g0, 3);
      check("t2_gap1", gaps[g0+1], 5);
      check("t2_gap2", gaps[g0+2], 5);
      check("t2_sent", frames_sent, 3);
      check("t2_captured", frames_captured, 3);
      check("t2_done_pulses", done_cnt - d0, 1);

      // gapless run with a start pulse while busy
      b0 = bursts.size();
      d0 = done_cnt;
      launch(2, 0, 2 * N);
      repeat (30) tick();
      num_frames = 5;
      gap = 3;
      start = 1;
      tick();
      start = 0;
      check("t3_busy_start_sent", frames_sent, 0);
      check("t3_busy_start_valid", src_valid, 1);
      wait_idle(600);
      check("t3_bursts", bursts.size() - b0, 1);
      check("t3_burst_len", bursts[b0], 128);
      check("t3_sent", frames_sent, 2);
      check("t3_captured", frames_captured, 2);
      check("t3_done_pulses", done_cnt - d0, 1);

      // continuity error
      drop = 1;
      launch(1, 0, N);
      wait_idle(400);
      check("t4_err", capture_err, 1);
      check("t4_captured", frames_captured, 1);
      repeat (5) tick();
      check("t4_err_sticky", capture_err, 1);
      readback();

      // abort in frame 2, then a clean rerun
      d0 = done_cnt;
      launch(4, 0, N + 31);
      check("t5_err_cleared", capture_err, 0);
      wait_sample(1, 30);
      abort = 1;
      flush = 1;
      tick();
      abort = 0;
      check("t5_valid_low", src_valid, 0);
      check("t5_busy", busy, 0);
      check("t5_sent", frames_sent, 1);
      check("t5_captured", frames_captured, 1);
      repeat (100) tick();
      check("t5_no_done", done_cnt - d0, 0);
      check("t5_sent_hold", frames_sent, 1);
      check("t5_captured_hold", frames_captured, 1);
      check("t5_err", capture_err, 0);
      d0 = done_cnt;
      launch(1, 0, N);
      wait_idle(400);
      check("t5_rerun_sent", frames_sent, 1);
      check("t5_rerun_captured", frames_captured, 1);
      check("t5_rerun_done", done_cnt - d0, 1);
      readback();

      // reset mid-play on a continuous run
      launch(0, 0, N + 11);
      wait_sample(1, 10);
      rst = 1;
      flush = 1;
      tick();
      check_reset_vals();
      rst = 0;
      repeat (20) tick();
      check("t6_idle_after_rst", src_valid, 0);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
